pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_pkg.sv | 16 +
 rtl/hazard_detect.sv | 22 ++
 rtl/pipe_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and default constants for the pipeline controller.
package pipe_pkg;

  localparam int unsigned REG_AW           = 5;
  localparam int unsigned PERF_W           = 32;
  localparam int unsigned DRAIN_CYCLES_DEF = 3;
  localparam int unsigned MWAIT_MAX_DEF    = 255;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MWAIT = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator between the ID-stage sources and the EX-stage load.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  output logic              load_use_c
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit  = id_rs1_used && (id_rs1 == ex_rd);
  assign w_rs2_hit  = id_rs2_used && (id_rs2 == ex_rd);
  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign load_use_c = ex_mem_read && (ex_rd != '0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: memory wait, redirect, load-use and halt drain.
// Define PIPE_CTRL_PERF_EN to add the stall_cnt/flush_cnt performance counters.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int unsigned MWAIT_MAX    = MWAIT_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_br_taken,
  input  logic              mem_req,
  input  logic              mem_ack,
  input  logic              halt_req,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              if_id_flush,
  output logic              id_ex_stall,
  output logic              id_ex_flush,
  output logic              ex_mem_stall,
  output logic              mem_wb_flush,
  output logic              halted,
  output logic              mem_timeout
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
`endif
);

  localparam int unsigned MW_W = (MWAIT_MAX > 0) ? $clog2(MWAIT_MAX + 1) : 1;
  localparam int unsigned DR_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  state_t          r_state, w_state_nxt;
  logic [MW_W-1:0] r_mw_cnt, w_mw_cnt_nxt;
  logic [DR_W-1:0] r_dr_cnt, w_dr_cnt_nxt;
  logic            r_timeout, w_timeout_nxt;
  logic            r_lu_prev, w_lu_prev_nxt;

  logic            w_load_use;
  logic            w_mem_wait;
  logic [MW_W-1:0] w_mw_inc;
  logic            w_mw_hit;

  hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use_c  (w_load_use)
  );

  assign w_mem_wait  = mem_req && !mem_ack;
  assign w_mw_inc    = r_mw_cnt + MW_W'(1);
  assign w_mw_hit    = (w_mw_inc >= MW_W'(MWAIT_MAX));
  assign halted      = (r_state == ST_HALT);
  assign mem_timeout = r_timeout;

  // Next-state and pipeline controls; r_lu_prev keeps a load-use bubble to one cycle
  always_comb begin
    w_state_nxt   = r_state;
    w_mw_cnt_nxt  = r_mw_cnt;
    w_dr_cnt_nxt  = r_dr_cnt;
    w_timeout_nxt = r_timeout;
    w_lu_prev_nxt = r_lu_prev;
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    id_ex_stall   = 1'b0;
    ex_mem_stall  = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_flush  = 1'b0;

    if (!rst) begin
      if (!en || (r_state == ST_HALT)) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
      end else begin
        w_lu_prev_nxt = 1'b0;
        case (r_state)
          ST_RUN: begin
            if (w_mem_wait) begin
              pc_stall     = 1'b1;
              if_id_stall  = 1'b1;
              id_ex_stall  = 1'b1;
              ex_mem_stall = 1'b1;
              mem_wb_flush = 1'b1;
              w_mw_cnt_nxt = w_mw_inc;
              w_state_nxt  = ST_MWAIT;
              if (w_mw_hit) begin
                w_timeout_nxt = 1'b1;
                w_state_nxt   = ST_HALT;
                w_mw_cnt_nxt  = '0;
              end
            end else if (ex_br_taken) begin
              if_id_flush = 1'b1;
              id_ex_flush = 1'b1;
            end else if (w_load_use && !r_lu_prev) begin
              pc_stall      = 1'b1;
              if_id_stall   = 1'b1;
              id_ex_flush   = 1'b1;
              w_lu_prev_nxt = 1'b1;
            end else if (halt_req) begin
              w_dr_cnt_nxt = DR_W'(DRAIN_CYCLES);
              w_state_nxt  = (DRAIN_CYCLES == 0) ? ST_HALT : ST_DRAIN;
            end
          end
          ST_MWAIT: begin
            if (mem_ack) begin
              w_mw_cnt_nxt = '0;
              w_state_nxt  = ST_RUN;
            end else begin
              pc_stall     = 1'b1;
              if_id_stall  = 1'b1;
              id_ex_stall  = 1'b1;
              ex_mem_stall = 1'b1;
              mem_wb_flush = 1'b1;
              w_mw_cnt_nxt = w_mw_inc;
              if (w_mw_hit) begin
                w_timeout_nxt = 1'b1;
                w_state_nxt   = ST_HALT;
                w_mw_cnt_nxt  = '0;
              end
            end
          end
          ST_DRAIN: begin
            // A memory wait freezes the drain count until the access completes
            if (w_mem_wait) begin
              pc_stall     = 1'b1;
              if_id_stall  = 1'b1;
              id_ex_stall  = 1'b1;
              ex_mem_stall = 1'b1;
              mem_wb_flush = 1'b1;
              w_mw_cnt_nxt = w_mw_inc;
              if (w_mw_hit) begin
                w_timeout_nxt = 1'b1;
                w_state_nxt   = ST_HALT;
                w_mw_cnt_nxt  = '0;
              end
            end else begin
              pc_stall     = 1'b1;
              if_id_flush  = 1'b1;
              w_mw_cnt_nxt = '0;
              if (r_dr_cnt <= DR_W'(1)) begin
                w_dr_cnt_nxt = '0;
                w_state_nxt  = ST_HALT;
              end else begin
                w_dr_cnt_nxt = r_dr_cnt - DR_W'(1);
              end
            end
          end
          default: w_state_nxt = r_state;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_RUN;
      r_mw_cnt  <= '0;
      r_dr_cnt  <= '0;
      r_timeout <= 1'b0;
      r_lu_prev <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mw_cnt  <= w_mw_cnt_nxt;
      r_dr_cnt  <= w_dr_cnt_nxt;
      r_timeout <= w_timeout_nxt;
      r_lu_prev <= w_lu_prev_nxt;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] r_stall_cnt;
  logic [PERF_W-1:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (pc_stall)    r_stall_cnt <= r_stall_cnt + PERF_W'(1);
      if (if_id_flush) r_flush_cnt <= r_flush_cnt + PERF_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl (DRAIN_CYCLES=3, MWAIT_MAX=8).
module tb_pipe_ctrl;

  // Output vector order: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
  // if_id_flush, id_ex_flush, mem_wb_flush, halted, mem_timeout
  localparam logic [8:0] E_NONE = 9'b000000000;
  localparam logic [8:0] E_LU   = 9'b110001000;
  localparam logic [8:0] E_BR   = 9'b000011000;
  localparam logic [8:0] E_MW   = 9'b111100100;
  localparam logic [8:0] E_EN0  = 9'b111100000;
  localparam logic [8:0] E_DR   = 9'b100010000;
  localparam logic [8:0] E_HALT = 9'b111100010;
  localparam logic [8:0] E_TMO  = 9'b111100011;

  typedef struct {
    string      tag;
    logic [8:0] exp;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_rs1_used, id_rs2_used, ex_mem_read, ex_br_taken;
  logic       mem_req, mem_ack, halt_req;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic       ex_mem_stall, mem_wb_flush, halted, mem_timeout;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  sb_t         sb_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] m_stall = 0;
  logic [31:0] m_flush = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.DRAIN_CYCLES(3), .MWAIT_MAX(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .ex_rd        (ex_rd),
    .ex_mem_read  (ex_mem_read),
    .ex_br_taken  (ex_br_taken),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .halt_req     (halt_req),
    .pc_stall     (pc_stall),
    .if_id_stall  (if_id_stall),
    .if_id_flush  (if_id_flush),
    .id_ex_stall  (id_ex_stall),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_stall (ex_mem_stall),
    .mem_wb_flush (mem_wb_flush),
    .halted       (halted),
    .mem_timeout  (mem_timeout)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_mem_read = 1'b0;
    ex_br_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0; halt_req = 1'b0;
  endtask

  // One clock cycle: push expectation, sample at negedge, advance past posedge
  task automatic cyc(input string tag, input logic [8:0] exp);
    sb_t        item;
    logic [8:0] obs;
    sb_q.push_back('{tag, exp});
    @(negedge clk);
    item = sb_q.pop_front();
    obs  = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
            if_id_flush, id_ex_flush, mem_wb_flush, halted, mem_timeout};
    n_chk++;
    assert (obs === item.exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", item.tag, obs, item.exp);
    end
    if (rst) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      m_stall = m_stall + 32'(item.exp[8]);
      m_flush = m_flush + 32'(item.exp[4]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_use_rs1();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    en  = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    cyc("rst_over_en", E_NONE);
    rst = 1'b0;
    en  = 1'b1;
    cyc("post_reset", E_NONE);

    load_use_rs1();
    cyc("load_use", E_LU);
    cyc("load_use_one_cycle", E_NONE);
    ex_rd = 5'd0; id_rs1 = 5'd0;
    cyc("load_use_rd0", E_NONE);
    idle();
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_rs2_used = 1'b1;
    cyc("load_use_rs2", E_LU);
    id_rs2_used = 1'b0;
    cyc("rs2_not_used", E_NONE);
    idle();
    load_use_rs1();
    ex_br_taken = 1'b1;
    cyc("redirect_plus_lu", E_BR);
    ex_br_taken = 1'b0;
    en = 1'b0;
    cyc("en_low_freeze", E_EN0);
    en = 1'b1;
    idle();
    cyc("idle_run", E_NONE);

    mem_req = 1'b1;
    cyc("mwait_1", E_MW);
    cyc("mwait_2", E_MW);
    ex_br_taken = 1'b1;
    cyc("mwait_3_br_ignored", E_MW);
    ex_br_taken = 1'b0;
    cyc("mwait_4", E_MW);
    mem_ack = 1'b1;
    cyc("mem_ack_cycle", E_NONE);
    idle();
    cyc("after_ack", E_NONE);

    halt_req = 1'b1;
    cyc("halt_accept", E_NONE);
    halt_req = 1'b0;
    cyc("drain_1", E_DR);
    rst = 1'b1;
    cyc("drain_2_rst", E_NONE);
    rst = 1'b0;
    cyc("drain_abort_run", E_NONE);
    cyc("drain_abort_run2", E_NONE);

    halt_req = 1'b1;
    cyc("halt_accept_b", E_NONE);
    halt_req = 1'b0;
    cyc("drainb_1", E_DR);
    mem_req = 1'b1;
    cyc("drainb_mwait_pause", E_MW);
    mem_req = 1'b0;
    load_use_rs1();
    ex_br_taken = 1'b1;
    cyc("drainb_2_ignores_br", E_DR);
    idle();
    cyc("drainb_3", E_DR);
    cyc("halted_1", E_HALT);
    halt_req = 1'b1; mem_req = 1'b1;
    cyc("halted_hold", E_HALT);
    idle();
    en = 1'b0;
    cyc("halted_en_low", E_HALT);
    en  = 1'b1;
    rst = 1'b1;
    cyc("rst_from_halt", 9'b000000010);
    rst = 1'b0;
    cyc("run_after_halt_rst", E_NONE);

    mem_req = 1'b1;
    for (int i = 1; i <= 8; i++) cyc($sformatf("tmo_wait_%0d", i), E_MW);
    cyc("timeout_set", E_TMO);
    mem_ack = 1'b1;
    cyc("timeout_sticky_ack", E_TMO);
    idle();
    cyc("timeout_sticky_idle", E_TMO);
    rst = 1'b1;
    cyc("rst_from_timeout", 9'b000000011);
    rst = 1'b0;
    cyc("timeout_cleared", E_NONE);

`ifdef PIPE_CTRL_PERF_EN
    n_chk++;
    assert (stall_cnt === m_stall) else begin
      n_fail++;
      $error("FAIL stall_cnt observed=%0d expected=%0d", stall_cnt, m_stall);
    end
    n_chk++;
    assert (flush_cnt === m_flush) else begin
      n_fail++;
      $error("FAIL flush_cnt observed=%0d expected=%0d", flush_cnt, m_flush);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
